// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and types for the sequential Booth multiplier
package mul_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Radix-4 Booth window codes, y[2:0] = {b[2i+1], b[2i], b[2i-1]}
  localparam logic [2:0] WIN_Z0  = 3'b000;
  localparam logic [2:0] WIN_P1A = 3'b001;
  localparam logic [2:0] WIN_P1B = 3'b010;
  localparam logic [2:0] WIN_P2  = 3'b011;
  localparam logic [2:0] WIN_M2  = 3'b100;
  localparam logic [2:0] WIN_M1A = 3'b101;
  localparam logic [2:0] WIN_M1B = 3'b110;
  localparam logic [2:0] WIN_Z1  = 3'b111;

endpackage

// File: rtl/booth_digit_sel.sv
// rtl/booth_digit_sel.sv - radix-4 Booth digit selector: window to magnitude plus negate flag
module booth_digit_sel
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic [2:0]     win,
  input  logic [WIDTH:0] x,
  output logic [WIDTH:0] mag,
  output logic           neg
);

  // x is already sign-extended by one bit, so a left shift keeps 2x exact
  logic [WIDTH:0] x2;
  assign x2 = {x[WIDTH-1:0], 1'b0};

  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (win)
      WIN_P1A, WIN_P1B: mag = x;
      WIN_P2:           mag = x2;
      WIN_M2: begin
        mag = x2;
        neg = 1'b1;
      end
      WIN_M1A, WIN_M1B: begin
        mag = x;
        neg = 1'b1;
      end
      default: begin
        mag = '0;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mul_tc_16_16_seq.sv
// rtl/mul_tc_16_16_seq.sv - sequential radix-4 Booth signed multiplier, one digit per cycle
module mul_tc_16_16_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = mul_pkg::WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int NDIG = WIDTH / 2;
  localparam int CW   = $clog2(NDIG);
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  state_t               state;
  logic [WIDTH:0]       x;
  logic [WIDTH:0]       y;
  logic [2*WIDTH+1:0]   acc;
  logic [CW-1:0]        cnt;

  logic [WIDTH:0]       mag;
  logic                 neg;
  logic [WIDTH+1:0]     mag_ext;
  logic [WIDTH+1:0]     pp;
  logic [2*WIDTH+1:0]   pp_ext;
  logic [2*WIDTH+1:0]   acc_next;

  booth_digit_sel #(
    .WIDTH(WIDTH)
  ) u_sel (
    .win(y[2:0]),
    .x  (x),
    .mag(mag),
    .neg(neg)
  );

  // Two extra bits: negating 2*(-2^(WIDTH-1)) yields +2^WIDTH
  always_comb begin
    mag_ext  = {mag[WIDTH], mag};
    pp       = neg ? (~mag_ext + 1'b1) : mag_ext;
    pp_ext   = {{WIDTH{pp[WIDTH+1]}}, pp};
    acc_next = acc + (pp_ext << {cnt, 1'b0});
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      p         <= '0;
      acc       <= '0;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x     <= {a[WIDTH-1], a};
            y     <= {b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          y   <= {y[WIDTH], y[WIDTH], y[WIDTH:2]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST_DIG) begin
            p         <= acc_next[2*WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
